// File: rtl/link_mem_if.sv
// Link-bus channel bundle between the UART link initiator and link_mem_responder.
// Every handshake (ar, aw, w, b) completes on a rising clk edge where valid and ready are both 1.
// The r channel has no ready, so each rvalid beat is accepted in the cycle it is shown.
interface link_mem_if;
    logic        arvalid;
    logic        arready;
    logic [27:0] araddr;
    logic [3:0]  arlen;
    logic [3:0]  aruserid;
    logic        aruserap;

    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        rlast;
    logic        rerr;

    logic        awvalid;
    logic        awready;
    logic [27:0] awaddr;
    logic [3:0]  awlen;
    logic [3:0]  awuserid;
    logic        awuserap;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;
    logic        berr;

    modport master (
        output arvalid, araddr, arlen, aruserid, aruserap,
        input  arready,
        input  rvalid, rdata, rid, rlast, rerr,
        output awvalid, awaddr, awlen, awuserid, awuserap,
        input  awready,
        output wvalid, wdata, wlast,
        input  wready,
        input  bvalid, bid, berr,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arlen, aruserid, aruserap,
        output arready,
        output rvalid, rdata, rid, rlast, rerr,
        input  awvalid, awaddr, awlen, awuserid, awuserap,
        output awready,
        input  wvalid, wdata, wlast,
        output wready,
        output bvalid, bid, berr,
        input  bready
    );
endinterface

// File: rtl/link_mem_responder.sv
// Burst read/write responder between the UART link bus and a synchronous single-port SRAM.
// Define LINK_RESP_ADDR_CHECK_EN to block and flag beats whose word address is >= MEM_DEPTH.
module link_mem_responder #(
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    link_mem_if.slave         bus,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_BURST = 3'd1,
        RD_DRAIN = 3'd2,
        WR_BURST = 3'd3,
        WR_RESP  = 3'd4
    } state_t;

    state_t      state;
    logic [27:0] addr;
    logic [3:0]  cnt;
    logic [3:0]  rid_q;
    logic [3:0]  bid_q;
    logic        berr_q;
    logic        rd_valid_q;
    logic        rd_last_q;
    logic        rd_err_q;
    logic        in_range;
    logic        rd_issue;
    logic        wr_beat;
    logic        unused_hints;

`ifdef LINK_RESP_ADDR_CHECK_EN
    assign in_range = ({4'b0, addr} < 32'(MEM_DEPTH));
`else
    logic [31:0] unused_depth;
    assign unused_depth = 32'(MEM_DEPTH);
    assign in_range     = 1'b1;
`endif

    assign unused_hints = bus.aruserap ^ bus.awuserap;
    assign rd_issue     = (state == RD_BURST);
    assign wr_beat      = (state == WR_BURST) && bus.wvalid;
    assign dbg_state    = state;

    always_comb begin
        bus.arready = (state == IDLE);
        // A simultaneous read request wins, so the write side backs off while arvalid is up.
        bus.awready = (state == IDLE) && !bus.arvalid;
        bus.wready  = (state == WR_BURST);
        bus.rvalid  = rd_valid_q;
        bus.rlast   = rd_last_q;
        bus.rid     = rid_q;
        bus.rerr    = rd_err_q;
        bus.rdata   = (rd_valid_q && !rd_err_q) ? mem_rdata : 32'h0;
        bus.bvalid  = (state == WR_RESP);
        bus.bid     = bid_q;
        bus.berr    = berr_q;
        mem_en      = (rd_issue || wr_beat) && in_range;
        mem_we      = wr_beat && in_range;
        mem_addr    = addr[ADDR_W-1:0];
        mem_wdata   = mem_we ? bus.wdata : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            cnt        <= '0;
            rid_q      <= '0;
            bid_q      <= '0;
            berr_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            // Read beat flags trail the SRAM access by one cycle, matching mem_rdata latency.
            rd_valid_q <= rd_issue;
            rd_last_q  <= rd_issue && (cnt == 4'd0);
            rd_err_q   <= rd_issue && !in_range;
            case (state)
                IDLE: begin
                    if (bus.arvalid) begin
                        addr  <= bus.araddr;
                        cnt   <= bus.arlen;
                        rid_q <= bus.aruserid;
                        state <= RD_BURST;
                    end else if (bus.awvalid) begin
                        addr   <= bus.awaddr;
                        cnt    <= bus.awlen;
                        bid_q  <= bus.awuserid;
                        berr_q <= 1'b0;
                        state  <= WR_BURST;
                    end
                end
                RD_BURST: begin
                    addr <= addr + 28'd1;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd0) state <= RD_DRAIN;
                end
                RD_DRAIN: state <= IDLE;
                WR_BURST: begin
                    if (bus.wvalid) begin
                        addr <= addr + 28'd1;
                        cnt  <= cnt - 4'd1;
                        // A beat that is last by count but not by wlast (or vice versa) is a mismatch.
                        if (!in_range || (bus.wlast != (cnt == 4'd0))) berr_q <= 1'b1;
                        if (bus.wlast || (cnt == 4'd0)) state <= WR_RESP;
                    end
                end
                WR_RESP: if (bus.bready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_link_mem_responder.sv
// Bench for link_mem_responder: transaction table, hand-written corner sequences and random
// bursts, all checked against a word-addressed reference memory and the burst timing rules.
module tb_link_mem_responder;

    localparam int ADDR_W = 16;
`ifdef LINK_RESP_ADDR_CHECK_EN
    localparam int DEPTH    = 16;
    localparam bit CHECK_EN = 1'b1;
`else
    localparam int DEPTH    = 65536;
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    link_mem_if bus();
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    bit   [31:0]       mem_rdata;
    logic [2:0]        dbg_state;

    link_mem_responder #(.ADDR_W(ADDR_W), .MEM_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .dbg_state (dbg_state)
    );

    // Synchronous single-port SRAM with one-cycle read latency.
    bit [31:0] sram [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    // Reference model: what each word should hold, and the read beats still owed.
    bit   [31:0] ref_mem [int];
    logic [31:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          is_wr;
        logic [27:0] addr;
        logic [3:0]  len;
        int          wl_pos;
        logic [3:0]  id;
        bit          exp_len_err;
    } vec_t;
    vec_t tbl [12];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit in_rng(logic [27:0] a);
        return !CHECK_EN || ({4'b0, a} < 32'(DEPTH));
    endfunction

    function automatic logic [31:0] ref_rd(logic [27:0] a);
        int key = int'(a[15:0]);
        return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.aruserid = '0; bus.aruserap = 0;
        bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0; bus.awuserid = '0; bus.awuserap = 0;
        bus.wvalid = 0; bus.wdata = '0; bus.wlast = 0; bus.bready = 0;
    endtask

    // Issue a read burst and check every cycle from handshake until the responder is idle again.
    task automatic do_read(input logic [27:0] addr, input logic [3:0] len, input logic [3:0] id);
        logic [27:0] a;
        logic [31:0] d;
        bit got = 0;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 28'(i);
            exp_q.push_back(in_rng(a) ? ref_rd(a) : 32'h0);
        end
        bus.arvalid = 1; bus.araddr = addr; bus.arlen = len; bus.aruserid = id;
        bus.aruserap = 1'($urandom_range(0, 1));
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (bus.arready) got = 1;
            else tick();
        end
        chk("ar_handshake", 32'(got), 1);
        if (!got) begin
            bus.arvalid = 0;
            exp_q.delete();
            return;
        end
        chk("awready_vs_arvalid", bus.awready, 0);
        tick();
        bus.arvalid = 0; bus.araddr = 28'($urandom); bus.arlen = 4'($urandom); bus.aruserid = 4'($urandom);
        for (int k = 0; k <= int'(len) + 2; k++) begin
            @(negedge clk);
            a = addr + 28'(k);
            if (k <= int'(len)) begin
                chk("rd_mem_en", mem_en, 32'(in_rng(a)));
                chk("rd_mem_we", mem_we, 0);
                if (in_rng(a)) chk("rd_mem_addr", mem_addr, a[15:0]);
            end else begin
                chk("rd_mem_en_done", mem_en, 0);
            end
            if (k >= 1 && k <= int'(len) + 1) begin
                d = exp_q.pop_front();
                chk("rvalid", bus.rvalid, 1);
                chk("rdata", bus.rdata, d);
                chk("rlast", bus.rlast, 32'(k == int'(len) + 1));
                chk("rid", bus.rid, id);
                chk("rerr", bus.rerr, 32'(!in_rng(addr + 28'(k - 1))));
            end else begin
                chk("rvalid_off", bus.rvalid, 0);
            end
            chk("arready", bus.arready, 32'(k == int'(len) + 2));
            chk("awready", bus.awready, 32'(k == int'(len) + 2));
            if (k < int'(len) + 2) tick();
        end
    endtask

    // Issue a write burst; wlast goes on beat wl_pos. pending means awvalid/awready are already up.
    task automatic do_write(input logic [27:0] addr, input logic [3:0] len, input int wl_pos,
                            input logic [3:0] id, input bit exp_len_err, input bit pending);
        logic [27:0] a;
        logic [31:0] d;
        bit got = pending;
        bit exp_berr = exp_len_err;
        int nb = (wl_pos < int'(len)) ? wl_pos + 1 : int'(len) + 1;
        int bd;
        bus.awaddr = addr; bus.awlen = len; bus.awuserid = id;
        if (!pending) begin
            bus.awvalid = 1;
            bus.awuserap = 1'($urandom_range(0, 1));
            for (int t = 0; t < 20 && !got; t++) begin
                @(negedge clk);
                if (bus.awready) got = 1;
                else tick();
            end
        end
        chk("aw_handshake", 32'(got), 1);
        if (!got) begin
            bus.awvalid = 0;
            return;
        end
        tick();
        bus.awvalid = 0; bus.awaddr = 28'($urandom); bus.awlen = 4'($urandom); bus.awuserid = 4'($urandom);
        for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 1)) begin
                bus.wvalid = 0; bus.wdata = $urandom; bus.wlast = 0;
                @(negedge clk);
                chk("wready_gap", bus.wready, 1);
                chk("wr_gap_mem_en", mem_en, 0);
                tick();
            end
            a = addr + 28'(i);
            d = $urandom;
            bus.wvalid = 1; bus.wdata = d; bus.wlast = (i == wl_pos);
            @(negedge clk);
            chk("wready", bus.wready, 1);
            chk("wr_mem_en", mem_en, 32'(in_rng(a)));
            chk("wr_mem_we", mem_we, 32'(in_rng(a)));
            if (in_rng(a)) begin
                chk("wr_mem_addr", mem_addr, a[15:0]);
                chk("wr_mem_wdata", mem_wdata, d);
                ref_mem[int'(a[15:0])] = d;
            end else begin
                exp_berr = 1;
            end
            tick();
        end
        bus.wvalid = 0; bus.wlast = 0;
        bd = $urandom_range(0, 2);
        for (int j = 0; j <= bd; j++) begin
            if (j == bd) bus.bready = 1;
            @(negedge clk);
            chk("bvalid", bus.bvalid, 1);
            chk("bid", bus.bid, id);
            chk("berr", bus.berr, 32'(exp_berr));
            chk("wready_resp", bus.wready, 0);
            chk("resp_mem_en", mem_en, 0);
            tick();
        end
        bus.bready = 0;
        @(negedge clk);
        chk("bvalid_done", bus.bvalid, 0);
        chk("awready_done", bus.awready, 1);
    endtask

    initial begin
        logic [3:0] rl;
        int wp;
        tbl[0]  = '{1'b1, 28'h10,      4'd3,  3,  4'd5,  1'b0};
        tbl[1]  = '{1'b0, 28'h10,      4'd3,  0,  4'd9,  1'b0};
        tbl[2]  = '{1'b1, 28'h20,      4'd3,  1,  4'd2,  1'b1};
        tbl[3]  = '{1'b0, 28'h20,      4'd3,  0,  4'd3,  1'b0};
        tbl[4]  = '{1'b1, 28'h30,      4'd1,  15, 4'd6,  1'b1};
        tbl[5]  = '{1'b1, 28'hFFFFFFE, 4'd3,  3,  4'd7,  1'b0};
        tbl[6]  = '{1'b0, 28'hFFFFFFE, 4'd3,  0,  4'd1,  1'b0};
        tbl[7]  = '{1'b0, 28'h5,       4'd0,  0,  4'd15, 1'b0};
        tbl[8]  = '{1'b1, 28'h100,     4'd15, 15, 4'd8,  1'b0};
        tbl[9]  = '{1'b0, 28'h100,     4'd15, 0,  4'd10, 1'b0};
        tbl[10] = '{1'b1, 28'h40,      4'd0,  0,  4'd11, 1'b0};
        tbl[11] = '{1'b0, 28'hF,       4'd1,  0,  4'd12, 1'b0};

        bus_idle();
        repeat (3) tick();
        rst_n = 1;
        @(negedge clk);
        chk("rst_arready", bus.arready, 1);
        chk("rst_awready", bus.awready, 1);
        chk("rst_rvalid", bus.rvalid, 0);
        chk("rst_rlast", bus.rlast, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_bvalid", bus.bvalid, 0);
        chk("rst_wready", bus.wready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);

        for (int i = 0; i < 12; i++) begin
            tick();
            if (tbl[i].is_wr)
                do_write(tbl[i].addr, tbl[i].len, tbl[i].wl_pos, tbl[i].id, tbl[i].exp_len_err, 1'b0);
            else
                do_read(tbl[i].addr, tbl[i].len, tbl[i].id);
        end

        // Simultaneous requests: the read goes first, the write is granted once idle again.
        tick();
        bus.awvalid = 1; bus.awaddr = 28'h50; bus.awlen = 4'd1; bus.awuserid = 4'd4;
        do_read(28'h10, 4'd3, 4'd6);
        do_write(28'h50, 4'd1, 1, 4'd4, 1'b0, 1'b1);
        tick();
        do_read(28'h50, 4'd1, 4'd13);

        // Reset in the middle of a read burst abandons it without a last beat.
        tick();
        bus.arvalid = 1; bus.araddr = 28'h10; bus.arlen = 4'd7; bus.aruserid = 4'd2;
        @(negedge clk);
        tick();
        bus.arvalid = 0;
        tick();
        @(negedge clk);
        chk("mid_rvalid", bus.rvalid, 1);
        rst_n = 0;
        #1;
        chk("rst_mid_rvalid", bus.rvalid, 0);
        chk("rst_mid_rlast", bus.rlast, 0);
        chk("rst_mid_mem_en", mem_en, 0);
        chk("rst_mid_arready", bus.arready, 1);
        tick();
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_rvalid", bus.rvalid, 0);
            chk("post_rst_rlast", bus.rlast, 0);
            chk("post_rst_bvalid", bus.bvalid, 0);
            tick();
        end
        do_write(28'h60, 4'd2, 2, 4'd3, 1'b0, 1'b0);
        tick();
        do_read(28'h60, 4'd2, 4'd5);

        for (int n = 0; n < 40; n++) begin
            tick();
            rl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'(rl);
                do_write(28'($urandom_range(0, 63)), rl, wp, 4'($urandom), wp != int'(rl), 1'b0);
            end else begin
                do_read(28'($urandom_range(0, 63)), rl, 4'($urandom));
            end
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: bench still running at %0t, limit 400000", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
